parking_time_sched: RTL and testbench
=====================================

PARKING_TIME_SCHED -- requirements
Module: parking_time_sched

Interface
REQ-001 Parameter NUM_SLOTS, default 8: number of parking slots tracked; legal range 2..16.
REQ-002 Parameter SLOT_W, default 3: slot index width; SHALL satisfy 2**SLOT_W >= NUM_SLOTS.
REQ-003 Parameter FEE_PER_MIN, default 10: fee units charged per elapsed minute.
REQ-004 Parameter GRACE_MIN, default 5: minutes free of charge.
REQ-005 clk  input  1  single system clock; all logic on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 time_now  input  16  minute count from the shared time counter; free-running and wraps at 2**16.
REQ-008 ent_req  input  1  entry gate request (4-phase handshake).
REQ-009 ent_ack  output  1  entry grant acknowledge.
REQ-010 ent_slot  output  SLOT_W  slot allocated to the entering car; valid while ent_ack=1.
REQ-011 ent_full  output  1  entry refused, lot full; valid while ent_ack=1.
REQ-012 ext_req  input  1  exit gate request (4-phase handshake).
REQ-013 ext_slot  input  SLOT_W  slot being vacated; stable while ext_req=1.
REQ-014 ext_ack  output  1  exit grant acknowledge.
REQ-015 ext_elapsed  output  16  parked minutes; valid while ext_ack=1.
REQ-016 ext_err  output  1  exit refused, slot not occupied or index >= NUM_SLOTS; valid while ext_ack=1.
REQ-017 ext_fee  output  16  fee for the exit; valid while ext_ack=1.
REQ-018 free_cnt  output  5  number of unoccupied slots.

Function
REQ-019 Block SHALL hold an occupancy bitmap and one 16-bit entry timestamp per slot; the single time_now sample path is shared by both gates.
REQ-020 FSM states SHALL be IDLE, SERVE_ENT, SERVE_EXT, RELEASE.
REQ-021 IDLE: only ent_req=1 -> SERVE_ENT; only ext_req=1 -> SERVE_EXT; both=1 -> round-robin, gate not served last wins; after reset entry wins the first tie.
REQ-022 SERVE_ENT, one cycle: if a slot is free, allocate the lowest-index free slot, set its bit, store time_now, ent_full=0; otherwise ent_full=1 and ent_slot=0, state unchanged; then -> RELEASE.
REQ-023 SERVE_EXT, one cycle: if ext_slot is valid and occupied, ext_elapsed = (time_now - stamp) mod 2**16, clear bit, ext_err=0; otherwise ext_err=1, ext_elapsed=0, ext_fee=0, state unchanged; then -> RELEASE.
REQ-024 The ack for the served gate SHALL assert in the cycle after SERVE_x (2-cycle latency from req sampled in IDLE) and stay high with its result outputs held until that gate's req is sampled low, then ack drops and FSM -> IDLE.
REQ-025 Only one ack SHALL be high at any time; a request arriving during service of the other gate waits in IDLE arbitration.
REQ-026 free_cnt SHALL update in the cycle after the bitmap changes and SHALL never exceed NUM_SLOTS or underflow.
REQ-027 A slot freed and reallocated later SHALL use the new timestamp; elapsed 0 (same-minute exit) is legal.

Reset
REQ-028 reset_n=0 SHALL immediately force state IDLE, all acks/flags/ent_slot/ext_elapsed/ext_fee to 0, bitmap cleared, free_cnt=NUM_SLOTS, round-robin priority to entry.
REQ-029 Reset mid-handshake SHALL abort the transaction; no partial bitmap update survives.

Configuration
REQ-030 Macro PARK_FEE_EN defined: ext_fee = 0 if elapsed <= GRACE_MIN, else (elapsed - GRACE_MIN) * FEE_PER_MIN saturated at 16'hFFFF, valid with ext_ack.
REQ-031 PARK_FEE_EN undefined: ext_fee port remains, tied to 0; no multiplier is synthesised.

Verification
REQ-032 Reset, ent_req at time_now=100 -> ent_ack with ent_slot=0, ent_full=0, free_cnt=7.
REQ-033 Fill 8 slots, 9th ent_req -> ent_full=1, free_cnt=0, bitmap unchanged.
REQ-034 Slot 2 entered at time_now=16'hFFF0, exit at 16'h0010 -> ext_elapsed=32, ext_fee=270 with PARK_FEE_EN, 0 without.
REQ-035 ent_req and ext_req rise same cycle twice in succession -> first served entry, second exit, never both acks high.
REQ-036 ext_req on empty slot 5 or ext_slot=9 with NUM_SLOTS=8 -> ext_err=1, ext_elapsed=0, free_cnt unchanged.
REQ-037 reset_n low during RELEASE of an entry -> all outputs 0, free_cnt=NUM_SLOTS at release of reset.

Source files
------------

// File: rtl/parking_time_sched_if.sv
// Gate-side bus for parking_time_sched: the entry and exit 4-phase handshakes
// and their result fields. The gate controller uses "master"; the scheduler
// uses "slave".
interface parking_time_sched_if #(
  parameter int SLOT_W = 3
) ();
  logic              ent_req;
  logic              ent_ack;
  logic [SLOT_W-1:0] ent_slot;
  logic              ent_full;
  logic              ext_req;
  logic [SLOT_W-1:0] ext_slot;
  logic              ext_ack;
  logic [15:0]       ext_elapsed;
  logic              ext_err;
  logic [15:0]       ext_fee;

  modport master (
    output ent_req, ext_req, ext_slot,
    input  ent_ack, ent_slot, ent_full, ext_ack, ext_elapsed, ext_err, ext_fee
  );

  modport slave (
    input  ent_req, ext_req, ext_slot,
    output ent_ack, ent_slot, ent_full, ext_ack, ext_elapsed, ext_err, ext_fee
  );
endinterface

// File: rtl/parking_time_sched.sv
// Parking lot time scheduler: tracks slot occupancy and entry timestamps,
// serves one entry or exit gate handshake at a time, and reports the parked
// time of exiting cars. Ties between the two gates are resolved round-robin.
// Optional feature macro PARK_FEE_EN: when defined, ext_fee carries the
// saturated parking fee; otherwise ext_fee is tied to zero.
module parking_time_sched #(
  parameter int NUM_SLOTS   = 8,
  parameter int SLOT_W      = 3,
  parameter int FEE_PER_MIN = 10,
  parameter int GRACE_MIN   = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          time_now,
  parking_time_sched_if.slave  gate,
  output logic [4:0]           free_cnt
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] SERVE_ENT = 2'd1;
  localparam logic [1:0] SERVE_EXT = 2'd2;
  localparam logic [1:0] RELEASE   = 2'd3;

  logic [1:0]           state_q,       state_d;
  logic                 last_ent_q,    last_ent_d;
  logic [NUM_SLOTS-1:0] occ_q,         occ_d;
  logic                 ent_ack_q,     ent_ack_d;
  logic [SLOT_W-1:0]    ent_slot_q,    ent_slot_d;
  logic                 ent_full_q,    ent_full_d;
  logic                 ext_ack_q,     ext_ack_d;
  logic [15:0]          ext_elapsed_q, ext_elapsed_d;
  logic                 ext_err_q,     ext_err_d;
  logic [15:0]          ext_fee_q,     ext_fee_d;
  logic [4:0]           free_cnt_q,    free_cnt_d;

  logic [15:0]          stamp_q [NUM_SLOTS];
  logic                 stamp_we;

  logic                 alloc_found;
  logic [SLOT_W-1:0]    alloc_idx;
  logic [NUM_SLOTS-1:0] alloc_mask;
  logic                 ext_hit;
  logic [15:0]          ext_stamp;
  logic [NUM_SLOTS-1:0] ext_mask;
  logic [15:0]          elapsed;

  function automatic logic [4:0] count_free(input logic [NUM_SLOTS-1:0] occ);
    logic [4:0] c;
    c = 5'(NUM_SLOTS);
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (occ[i]) c = c - 5'd1;
    end
    return c;
  endfunction

`ifdef PARK_FEE_EN
  function automatic logic [15:0] fee_sat(input logic [15:0] el);
    logic [31:0] prod;
    if (el <= 16'(GRACE_MIN)) return 16'd0;
    prod = 32'(el - 16'(GRACE_MIN)) * 32'(FEE_PER_MIN);
    return (prod > 32'h0000_FFFF) ? 16'hFFFF : prod[15:0];
  endfunction
`endif

  // Lowest-index free slot (scan downward so the lowest index wins last).
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    alloc_mask  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occ_q[i]) begin
        alloc_found   = 1'b1;
        alloc_idx     = SLOT_W'(i);
        alloc_mask    = '0;
        alloc_mask[i] = 1'b1;
      end
    end
  end

  // Exit slot lookup; indices >= NUM_SLOTS never match and so report an error.
  always_comb begin
    ext_hit   = 1'b0;
    ext_stamp = '0;
    ext_mask  = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (gate.ext_slot == SLOT_W'(i) && occ_q[i]) begin
        ext_hit     = 1'b1;
        ext_stamp   = stamp_q[i];
        ext_mask[i] = 1'b1;
      end
    end
    elapsed = time_now - ext_stamp;
  end

  // Arbitration, service and release of the gate handshakes.
  always_comb begin
    state_d       = state_q;
    last_ent_d    = last_ent_q;
    occ_d         = occ_q;
    ent_ack_d     = ent_ack_q;
    ent_slot_d    = ent_slot_q;
    ent_full_d    = ent_full_q;
    ext_ack_d     = ext_ack_q;
    ext_elapsed_d = ext_elapsed_q;
    ext_err_d     = ext_err_q;
    ext_fee_d     = ext_fee_q;
    stamp_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (gate.ent_req && (!gate.ext_req || !last_ent_q)) begin
          state_d = SERVE_ENT;
        end else if (gate.ext_req) begin
          state_d = SERVE_EXT;
        end
      end
      SERVE_ENT: begin
        ent_ack_d  = 1'b1;
        last_ent_d = 1'b1;
        ent_full_d = !alloc_found;
        ent_slot_d = alloc_found ? alloc_idx : '0;
        if (alloc_found) begin
          occ_d    = occ_q | alloc_mask;
          stamp_we = 1'b1;
        end
        state_d = RELEASE;
      end
      SERVE_EXT: begin
        ext_ack_d  = 1'b1;
        last_ent_d = 1'b0;
        if (ext_hit) begin
          occ_d         = occ_q & ~ext_mask;
          ext_elapsed_d = elapsed;
          ext_err_d     = 1'b0;
`ifdef PARK_FEE_EN
          ext_fee_d     = fee_sat(elapsed);
`else
          ext_fee_d     = '0;
`endif
        end else begin
          ext_elapsed_d = '0;
          ext_err_d     = 1'b1;
          ext_fee_d     = '0;
        end
        state_d = RELEASE;
      end
      default: begin
        // RELEASE: hold results until the served gate withdraws its request.
        if (last_ent_q ? !gate.ent_req : !gate.ext_req) begin
          ent_ack_d     = 1'b0;
          ent_slot_d    = '0;
          ent_full_d    = 1'b0;
          ext_ack_d     = 1'b0;
          ext_elapsed_d = '0;
          ext_err_d     = 1'b0;
          ext_fee_d     = '0;
          state_d       = IDLE;
        end
      end
    endcase
    free_cnt_d = count_free(occ_d);
  end

  // Control, occupancy and result registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_ent_q    <= 1'b0;
      occ_q         <= '0;
      ent_ack_q     <= 1'b0;
      ent_slot_q    <= '0;
      ent_full_q    <= 1'b0;
      ext_ack_q     <= 1'b0;
      ext_elapsed_q <= '0;
      ext_err_q     <= 1'b0;
      ext_fee_q     <= '0;
      free_cnt_q    <= 5'(NUM_SLOTS);
    end else begin
      state_q       <= state_d;
      last_ent_q    <= last_ent_d;
      occ_q         <= occ_d;
      ent_ack_q     <= ent_ack_d;
      ent_slot_q    <= ent_slot_d;
      ent_full_q    <= ent_full_d;
      ext_ack_q     <= ext_ack_d;
      ext_elapsed_q <= ext_elapsed_d;
      ext_err_q     <= ext_err_d;
      ext_fee_q     <= ext_fee_d;
      free_cnt_q    <= free_cnt_d;
    end
  end

  // Entry timestamps are pure data, only meaningful while the slot bit is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (stamp_we && alloc_mask[i]) stamp_q[i] <= time_now;
    end
  end

  assign gate.ent_ack     = ent_ack_q;
  assign gate.ent_slot    = ent_slot_q;
  assign gate.ent_full    = ent_full_q;
  assign gate.ext_ack     = ext_ack_q;
  assign gate.ext_elapsed = ext_elapsed_q;
  assign gate.ext_err     = ext_err_q;
  assign gate.ext_fee     = ext_fee_q;
  assign free_cnt         = free_cnt_q;

endmodule

// File: tb/tb_parking_time_sched.sv
// Scoreboard bench for parking_time_sched: a lot-level model predicts each
// gate response when the request is issued; a monitor checks the DUT result
// whenever an ack rises.
module tb_parking_time_sched;
  localparam int NS    = 8;
  localparam int SW    = 4;
  localparam int FEE   = 10;
  localparam int GRACE = 5;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] time_now;
  logic [4:0]  free_cnt;

  parking_time_sched_if #(.SLOT_W(SW)) bus ();

  parking_time_sched #(
    .NUM_SLOTS(NS), .SLOT_W(SW), .FEE_PER_MIN(FEE), .GRACE_MIN(GRACE)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .time_now (time_now),
    .gate     (bus),
    .free_cnt (free_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_ent;
    int slot;
    bit full;
    int elapsed;
    bit err;
    int fee;
    int free;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Lot model: who is parked where, since when, and which gate went last.
  bit m_occ[NS];
  int m_stamp[NS];
  bit m_last_ent;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int m_free();
    int c = 0;
    for (int i = 0; i < NS; i++) if (!m_occ[i]) c++;
    return c;
  endfunction

  function automatic int m_fee(int el);
`ifdef PARK_FEE_EN
    int f;
    if (el <= GRACE) return 0;
    f = (el - GRACE) * FEE;
    return (f > 65535) ? 65535 : f;
`else
    return 0;
`endif
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
    m_last_ent = 1'b0;
    sb.delete();
  endfunction

  function automatic void model_ent(int t);
    exp_t e;
    int   s = -1;
    for (int i = 0; i < NS; i++) if (!m_occ[i] && s < 0) s = i;
    e.is_ent = 1'b1; e.elapsed = 0; e.err = 1'b0; e.fee = 0;
    if (s < 0) begin
      e.full = 1'b1; e.slot = 0;
    end else begin
      e.full = 1'b0; e.slot = s;
      m_occ[s] = 1'b1; m_stamp[s] = t & 16'hFFFF;
    end
    e.free = m_free();
    m_last_ent = 1'b1;
    sb.push_back(e);
  endfunction

  function automatic void model_ext(int s, int t);
    exp_t e;
    e.is_ent = 1'b0; e.slot = 0; e.full = 1'b0;
    if (s < NS && m_occ[s]) begin
      e.elapsed = ((t & 16'hFFFF) - m_stamp[s]) & 16'hFFFF;
      e.err = 1'b0;
      e.fee = m_fee(e.elapsed);
      m_occ[s] = 1'b0;
    end else begin
      e.elapsed = 0; e.err = 1'b1; e.fee = 0;
    end
    e.free = m_free();
    m_last_ent = 1'b0;
    sb.push_back(e);
  endfunction

  // Monitor: compares against the scoreboard on every rising ack.
  bit pe = 1'b0;
  bit px = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (bus.ent_ack && bus.ext_ack) chk("both_acks_high", 1, 0);
    if (reset_n) begin
      if (bus.ent_ack && !pe) begin
        if (sb.size() == 0) chk("ent_ack_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ent_gate_order", 1, int'(e.is_ent));
          chk("ent_slot", int'(bus.ent_slot), e.slot);
          chk("ent_full", int'(bus.ent_full), int'(e.full));
          chk("ent_free_cnt", int'(free_cnt), e.free);
        end
      end
      if (bus.ext_ack && !px) begin
        if (sb.size() == 0) chk("ext_ack_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("ext_gate_order", 0, int'(e.is_ent));
          chk("ext_elapsed", int'(bus.ext_elapsed), e.elapsed);
          chk("ext_err", int'(bus.ext_err), int'(e.err));
          chk("ext_fee", int'(bus.ext_fee), e.fee);
          chk("ext_free_cnt", int'(free_cnt), e.free);
        end
      end
    end
    pe = bus.ent_ack;
    px = bus.ext_ack;
  end

  task automatic wait_ack(input bit is_ent, input bit lvl, input string name);
    int n = 0;
    while (((is_ent ? bus.ent_ack : bus.ext_ack) != lvl) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 30) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout, ack still %0d, expected %0d", name, !lvl, lvl);
    end
  endtask

  task automatic do_ent(input int t);
    @(posedge clk); #1;
    time_now = 16'(t);
    model_ent(t);
    bus.ent_req = 1'b1;
    wait_ack(1'b1, 1'b1, "ent_ack_rise");
    bus.ent_req = 1'b0;
    wait_ack(1'b1, 1'b0, "ent_ack_fall");
  endtask

  task automatic do_ext(input int s, input int t);
    @(posedge clk); #1;
    time_now = 16'(t);
    bus.ext_slot = SW'(s);
    model_ext(s, t);
    bus.ext_req = 1'b1;
    wait_ack(1'b0, 1'b1, "ext_ack_rise");
    bus.ext_req = 1'b0;
    wait_ack(1'b0, 1'b0, "ext_ack_fall");
  endtask

  task automatic do_tie(input int s, input int t);
    bit first_ent;
    @(posedge clk); #1;
    time_now = 16'(t);
    bus.ext_slot = SW'(s);
    first_ent = !m_last_ent;
    if (first_ent) begin model_ent(t); model_ext(s, t); end
    else begin model_ext(s, t); model_ent(t); end
    bus.ent_req = 1'b1;
    bus.ext_req = 1'b1;
    wait_ack(first_ent, 1'b1, "tie_first_rise");
    if (first_ent) bus.ent_req = 1'b0; else bus.ext_req = 1'b0;
    wait_ack(first_ent, 1'b0, "tie_first_fall");
    wait_ack(!first_ent, 1'b1, "tie_second_rise");
    if (first_ent) bus.ext_req = 1'b0; else bus.ent_req = 1'b0;
    wait_ack(!first_ent, 1'b0, "tie_second_fall");
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ent_ack"},     int'(bus.ent_ack), 0);
    chk({tag, "_ent_slot"},    int'(bus.ent_slot), 0);
    chk({tag, "_ent_full"},    int'(bus.ent_full), 0);
    chk({tag, "_ext_ack"},     int'(bus.ext_ack), 0);
    chk({tag, "_ext_elapsed"}, int'(bus.ext_elapsed), 0);
    chk({tag, "_ext_err"},     int'(bus.ext_err), 0);
    chk({tag, "_ext_fee"},     int'(bus.ext_fee), 0);
    chk({tag, "_free_cnt"},    int'(free_cnt), NS);
  endtask

  initial begin
    int cur;
    int op;
    bus.ent_req  = 1'b0;
    bus.ext_req  = 1'b0;
    bus.ext_slot = '0;
    time_now     = 16'd0;
    reset_n      = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_idle_outputs("in_reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("after_reset");

    // First entry after reset, then fill the lot with slot 2 at 0xFFF0.
    do_ent(100);
    do_ent(200);
    do_ent(16'hFFF0);
    for (int i = 0; i < 5; i++) do_ent(300 + i);
    do_ent(400);                       // lot full
    do_ext(2, 16'h0010);               // wraps: 32 minutes
    do_ext(5, 500);
    do_ext(5, 510);                    // now empty
    do_ext(9, 520);                    // out of range
    do_ent(530);                       // reuses slot 2 with a fresh stamp
    do_ext(2, 531);

    // Reset while an entry is being held in release.
    @(posedge clk); #1;
    time_now = 16'd600;
    model_ent(600);
    bus.ent_req = 1'b1;
    wait_ack(1'b1, 1'b1, "rst_ent_ack_rise");
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 chk_idle_outputs("mid_release_reset");
    bus.ent_req = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("reset_release");

    // Two simultaneous requests in succession right after reset.
    do_tie(0, 1000);                   // entry to slot 0, then same-minute exit
    do_tie(3, 1010);

    // Randomised traffic.
    cur = 2000;
    for (int k = 0; k < 250; k++) begin
      cur = cur + int'($urandom_range(0, 40));
      if ($urandom_range(0, 19) == 0) cur = cur + int'($urandom_range(0, 65535));
      op = int'($urandom_range(0, 3));
      case (op)
        0, 1: do_ent(cur);
        2:    do_ext(int'($urandom_range(0, 9)), cur);
        default: do_tie(int'($urandom_range(0, 9)), cur);
      endcase
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
